// File: rtl/vga_timing_gen_pkg.sv
// Shared types and default 640x480@60 constants for the VGA raster timing generator.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN (adds frame_count).
package vga_timing_gen_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;
    localparam bit          VGA_SYNC_POL = 1'b0;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CNT_MAX = 1 << CNT_W;

    typedef logic [CNT_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   active;
        logic   hsync;
        logic   vsync;
        logic   line_end;
        logic   frame_end;
    } vga_timing_t;

    function automatic logic sync_level(input logic asserted, input bit pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-enable plus raster timing bundle between the generator and its consumers.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN (adds frame_count).
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    logic   ce;
    coord_t x;
    coord_t y;
    logic   active;
    logic   hsync;
    logic   vsync;
    logic   line_end;
    logic   frame_end;
`ifdef VGA_TIMING_FRAME_CNT_EN
    coord_t frame_count;

    modport master (
        input  ce,
        output x, y, active, hsync, vsync,
        output line_end, frame_end, frame_count
    );

    modport slave (
        output ce,
        input  x, y, active, hsync, vsync,
        input  line_end, frame_end, frame_count
    );
`else
    modport master (
        input  ce,
        output x, y, active, hsync, vsync,
        output line_end, frame_end
    );

    modport slave (
        output ce,
        input  x, y, active, hsync, vsync,
        input  line_end, frame_end
    );
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis: count, terminal-count flag and sync-window flag.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN (not used here).
module vga_axis_counter #(
    parameter int unsigned TOTAL     = 800,
    parameter int unsigned WIN_START = 656,
    parameter int unsigned WIN_LEN   = 96,
    parameter int unsigned W         = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         in_win
);

    typedef logic [W-1:0] cnt_t;
    typedef logic [W:0]   ext_t;

    // Window bounds can reach TOTAL, so compare one bit wider than the count.
    localparam cnt_t LAST   = cnt_t'(TOTAL - 1);
    localparam ext_t WIN_LO = ext_t'(WIN_START);
    localparam ext_t WIN_HI = ext_t'(WIN_START + WIN_LEN);

    ext_t cnt_x;

    assign tc     = (cnt == LAST);
    assign cnt_x  = {1'b0, cnt};
    assign in_win = (cnt_x >= WIN_LO) && (cnt_x < WIN_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: x/y, active, hsync/vsync and line/frame pulses, one ce behind the counters.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN (adds frame_count to the interface).
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT  = VGA_H_FRONT,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BACK   = VGA_H_BACK,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT  = VGA_V_FRONT,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BACK   = VGA_V_BACK,
    parameter bit          SYNC_POL = VGA_SYNC_POL
) (
    input  logic            clk,
    input  logic            rst,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);

    if (H_TOTAL > CNT_MAX) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > CNT_MAX) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    coord_t      h_cnt;
    coord_t      v_cnt;
    logic        h_tc;
    logic        v_tc;
    logic        h_win;
    logic        v_win;
    logic        v_inc;
    vga_timing_t nxt;
    vga_timing_t cur;

    assign v_inc = vga.ce & h_tc;

    vga_axis_counter #(
        .TOTAL     (H_TOTAL),
        .WIN_START (H_ACTIVE + H_FRONT),
        .WIN_LEN   (H_SYNC),
        .W         (CNT_W)
    ) u_h_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (vga.ce),
        .cnt    (h_cnt),
        .tc     (h_tc),
        .in_win (h_win)
    );

    vga_axis_counter #(
        .TOTAL     (V_TOTAL),
        .WIN_START (V_ACTIVE + V_FRONT),
        .WIN_LEN   (V_SYNC),
        .W         (CNT_W)
    ) u_v_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (v_inc),
        .cnt    (v_cnt),
        .tc     (v_tc),
        .in_win (v_win)
    );

    // All outputs are decoded from the same counter snapshot so they stay aligned.
    always_comb begin
        nxt           = '0;
        nxt.x         = h_cnt;
        nxt.y         = v_cnt;
        nxt.active    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        nxt.hsync     = sync_level(h_win, SYNC_POL);
        nxt.vsync     = sync_level(v_win, SYNC_POL);
        nxt.line_end  = h_tc;
        nxt.frame_end = h_tc & v_tc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur.x         <= '0;
            cur.y         <= '0;
            cur.active    <= 1'b0;
            cur.hsync     <= ~SYNC_POL;
            cur.vsync     <= ~SYNC_POL;
            cur.line_end  <= 1'b0;
            cur.frame_end <= 1'b0;
        end else if (vga.ce) begin
            cur <= nxt;
        end
    end

    assign vga.x         = cur.x;
    assign vga.y         = cur.y;
    assign vga.active    = cur.active;
    assign vga.hsync     = cur.hsync;
    assign vga.vsync     = cur.vsync;
    assign vga.line_end  = cur.line_end;
    assign vga.frame_end = cur.frame_end;

`ifdef VGA_TIMING_FRAME_CNT_EN
    coord_t frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (vga.ce && cur.frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign vga.frame_count = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance for line checks, reduced instance for frames.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN (frame_count also scoreboarded).
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    localparam int SHA = 40;
    localparam int SHF = 4;
    localparam int SHS = 8;
    localparam int SHB = 6;
    localparam int SVA = 30;
    localparam int SVF = 3;
    localparam int SVS = 2;
    localparam int SVB = 5;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;
    localparam int SFRAME = SHT * SVT;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       line_end;
        logic       frame_end;
    } exp_t;

    localparam exp_t RST_E = '{x: 10'd0, y: 10'd0, active: 1'b0, hsync: 1'b1,
                               vsync: 1'b1, line_end: 1'b0, frame_end: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    int tests = 0;
    int fails = 0;

    exp_t q[$];
    exp_t last;
    int   mh;
    int   mv;
    int   mfc;

    vga_timing_gen_if dif ();
    vga_timing_gen_if sif ();

    assign dif.ce = ce;
    assign sif.ce = ce;

    vga_timing_gen u_def (
        .clk (clk),
        .rst (rst),
        .vga (dif)
    );

    vga_timing_gen #(
        .H_ACTIVE (SHA), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_ACTIVE (SVA), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .SYNC_POL (1'b0)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .vga (sif)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int h, input int v);
        exp_t e;
        e.x         = h[9:0];
        e.y         = v[9:0];
        e.active    = (h < SHA) && (v < SVA);
        e.hsync     = !((h >= SHA + SHF) && (h < SHA + SHF + SHS));
        e.vsync     = !((v >= SVA + SVF) && (v < SVA + SVF + SVS));
        e.line_end  = (h == SHT - 1);
        e.frame_end = (h == SHT - 1) && (v == SVT - 1);
        return e;
    endfunction

    function automatic exp_t obs_small();
        exp_t o;
        o.x         = sif.x;
        o.y         = sif.y;
        o.active    = sif.active;
        o.hsync     = sif.hsync;
        o.vsync     = sif.vsync;
        o.line_end  = sif.line_end;
        o.frame_end = sif.frame_end;
        return o;
    endfunction

    function automatic exp_t obs_def();
        exp_t o;
        o.x         = dif.x;
        o.y         = dif.y;
        o.active    = dif.active;
        o.hsync     = dif.hsync;
        o.vsync     = dif.vsync;
        o.line_end  = dif.line_end;
        o.frame_end = dif.frame_end;
        return o;
    endfunction

    task automatic model_reset();
        mh   = 0;
        mv   = 0;
        mfc  = 0;
        last = RST_E;
        q.delete();
    endtask

    // One clk with the given ce; the reduced instance is scoreboarded every cycle.
    task automatic step(input logic c);
        exp_t exp_v;
        exp_t got;
        int   fc_exp;
        ce = c;
        if (c) begin
            if (last.frame_end) mfc = (mfc + 1) % 1024;
            q.push_back(model(mh, mv));
            if (mh == SHT - 1) begin
                mh = 0;
                mv = (mv == SVT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        fc_exp = mfc;
        @(posedge clk);
        #1;
        exp_v = (q.size() > 0) ? q.pop_front() : last;
        last  = exp_v;
        got   = obs_small();
        tests++;
        if (got !== exp_v) begin
            fails++;
            if (fails <= 20)
                $display("FAIL scoreboard t=%0t got x=%0d y=%0d a=%b hs=%b vs=%b le=%b fe=%b exp x=%0d y=%0d a=%b hs=%b vs=%b le=%b fe=%b",
                         $time, got.x, got.y, got.active, got.hsync, got.vsync, got.line_end, got.frame_end,
                         exp_v.x, exp_v.y, exp_v.active, exp_v.hsync, exp_v.vsync, exp_v.line_end, exp_v.frame_end);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        tests++;
        if (sif.frame_count !== fc_exp[9:0]) begin
            fails++;
            if (fails <= 20)
                $display("FAIL frame_count got=%0d exp=%0d", sif.frame_count, fc_exp);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (obs_small() !== RST_E) begin
            fails++;
            $display("FAIL reset_small got=%h exp=%h", obs_small(), RST_E);
        end
        tests++;
        if (obs_def() !== RST_E) begin
            fails++;
            $display("FAIL reset_def got=%h exp=%h", obs_def(), RST_E);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        tests++;
        if (sif.frame_count !== 10'd0) begin
            fails++;
            $display("FAIL reset_frame_count got=%0d exp=0", sif.frame_count);
        end
`endif
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_line();
        int hs_low = 0;
        int hs_min = 1023;
        int hs_max = 0;
        int le_cnt = 0;
        int le_x   = 0;
        int act    = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b1);
            if (i == 0) begin
                tests++;
                if ({dif.x, dif.y, dif.active, dif.hsync, dif.vsync} !== {10'd0, 10'd0, 3'b111}) begin
                    fails++;
                    $display("FAIL first_pixel got x=%0d y=%0d a=%b hs=%b vs=%b exp x=0 y=0 a=1 hs=1 vs=1",
                             dif.x, dif.y, dif.active, dif.hsync, dif.vsync);
                end
            end
            if (!dif.hsync) begin
                hs_low++;
                if (int'(dif.x) < hs_min) hs_min = int'(dif.x);
                if (int'(dif.x) > hs_max) hs_max = int'(dif.x);
            end
            if (dif.line_end) begin
                le_cnt++;
                le_x = int'(dif.x);
            end
            if (dif.active) act++;
        end
        step(1'b1);
        tests++;
        if (dif.x !== 10'd0 || dif.y !== 10'd1) begin
            fails++;
            $display("FAIL line_wrap got x=%0d y=%0d exp x=0 y=1", dif.x, dif.y);
        end
        tests++;
        if (hs_low != 96 || hs_min != 656 || hs_max != 751) begin
            fails++;
            $display("FAIL hsync_window got len=%0d lo=%0d hi=%0d exp len=96 lo=656 hi=751",
                     hs_low, hs_min, hs_max);
        end
        tests++;
        if (le_cnt != 1 || le_x != 799) begin
            fails++;
            $display("FAIL line_end got cnt=%0d x=%0d exp cnt=1 x=799", le_cnt, le_x);
        end
        tests++;
        if (act != 640) begin
            fails++;
            $display("FAIL line_active got=%0d exp=640", act);
        end
    endtask

    task automatic test_frame();
        int n     = 0;
        int cyc   = 0;
        int edges = 0;
        int vlow  = 0;
        int act   = 0;
        int ex    = -1;
        int ey    = -1;
        logic pv;
        while (!sif.frame_end && n < 3 * SFRAME) begin
            step(1'b1);
            n++;
        end
        tests++;
        if (!sif.frame_end) begin
            fails++;
            $display("FAIL frame_sync timeout got=0 exp=1");
            return;
        end
        pv = sif.vsync;
        do begin
            step(1'b1);
            cyc++;
            if (!pv && sif.vsync) begin
                edges++;
                ex = int'(sif.x);
                ey = int'(sif.y);
            end
            pv = sif.vsync;
            if (!sif.vsync) vlow++;
            if (sif.active) act++;
        end while (!sif.frame_end && cyc < 2 * SFRAME);
        tests++;
        if (cyc != SFRAME) begin
            fails++;
            $display("FAIL frame_period got=%0d exp=%0d", cyc, SFRAME);
        end
        tests++;
        if (edges != 1 || ex != 0 || ey != SVA + SVF + SVS) begin
            fails++;
            $display("FAIL vsync_rise got n=%0d x=%0d y=%0d exp n=1 x=0 y=%0d",
                     edges, ex, ey, SVA + SVF + SVS);
        end
        tests++;
        if (vlow != SVS * SHT || act != SHA * SVA) begin
            fails++;
            $display("FAIL frame_counts got vlow=%0d act=%0d exp vlow=%0d act=%0d",
                     vlow, act, SVS * SHT, SHA * SVA);
        end
    endtask

    task automatic test_ce_toggle();
        logic ph = 1'b1;
        logic pf;
        int   n     = 0;
        int   per   = 0;
        int   fe_hi = 0;
        int   le_hi = 0;
        bit   found = 0;
        pf = sif.frame_end;
        while (!found && n < 3 * 2 * SFRAME) begin
            step(ph);
            ph = ~ph;
            n++;
            if (!pf && sif.frame_end) found = 1;
            pf = sif.frame_end;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL ce_sync timeout got=0 exp=1");
            return;
        end
        found = 0;
        while (!found && per < 3 * 2 * SFRAME) begin
            step(ph);
            ph = ~ph;
            per++;
            if (sif.frame_end) fe_hi++;
            if (sif.line_end) le_hi++;
            if (!pf && sif.frame_end) found = 1;
            pf = sif.frame_end;
        end
        tests++;
        if (per != 2 * SFRAME) begin
            fails++;
            $display("FAIL ce_frame_period got=%0d exp=%0d", per, 2 * SFRAME);
        end
        tests++;
        if (fe_hi != 2 || le_hi != 2 * SVT) begin
            fails++;
            $display("FAIL ce_pulse_width got fe=%0d le=%0d exp fe=2 le=%0d", fe_hi, le_hi, 2 * SVT);
        end
        if (ph == 1'b0) step(1'b0);
    endtask

    task automatic test_reset_mid();
        int   n  = 0;
        int   tx = SHA + SHF + 2;
        int   ty = SVA + SVF;
        exp_t od;
        while (!(int'(sif.x) == tx && int'(sif.y) == ty) && n < 3 * SFRAME) begin
            step(1'b1);
            n++;
        end
        tests++;
        if (sif.hsync !== 1'b0 || sif.vsync !== 1'b0) begin
            fails++;
            $display("FAIL mid_precond got hs=%b vs=%b x=%0d y=%0d exp hs=0 vs=0 x=%0d y=%0d",
                     sif.hsync, sif.vsync, sif.x, sif.y, tx, ty);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (obs_small() !== RST_E) begin
            fails++;
            $display("FAIL mid_reset_async got=%h exp=%h", obs_small(), RST_E);
        end
        od = obs_def();
        tests++;
        if (od !== RST_E) begin
            fails++;
            $display("FAIL mid_reset_def got=%h exp=%h", od, RST_E);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * SHT + 5; i++) step(1'b1);
        tests++;
        if (dif.y !== 10'd0 || int'(dif.x) != 2 * SHT + 4) begin
            fails++;
            $display("FAIL mid_restart_def got x=%0d y=%0d exp x=%0d y=0", dif.x, dif.y, 2 * SHT + 4);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_line();
        test_frame();
        test_ce_toggle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
